// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } mult_state_t;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - IDLE/CALC/DONE control and iteration down-counter
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic ready,
    output logic done
);

    localparam int CW = count_width(WIDTH);

    mult_state_t     state_q;
    logic [CW-1:0]   count_q;
    logic            ready_q;
    logic            done_q;
    logic            count_last;

    assign count_last = (count_q == CW'(1));

    // Strobes for the datapath; finish marks the final iteration edge
    assign load   = (state_q == ST_IDLE) && start;
    assign step   = (state_q == ST_CALC);
    assign finish = step && count_last;
    assign ready  = ready_q;
    assign done   = done_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_CALC;
                        count_q <= CW'(WIDTH);
                        ready_q <= 1'b0;
                    end
                end
                ST_CALC: begin
                    count_q <= count_q - CW'(1);
                    if (count_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier with optional two's-complement mode
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 done
);

    logic               load;
    logic               step;
    logic               finish;

    // ca_q holds {C, A}; C is the carry out of the accumulate
    logic [WIDTH:0]     ca_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   m_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   mcand_mag;
    logic [WIDTH-1:0]   mplier_mag;
    logic               neg_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     ca_d;
    logic [WIDTH-1:0]   q_d;
    logic [2*WIDTH-1:0] raw_prod;
    logic [2*WIDTH-1:0] product_d;

    mult_sequencer #(
        .WIDTH (WIDTH)
    ) u_seq (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .load   (load),
        .step   (step),
        .finish (finish),
        .ready  (ready),
        .done   (done)
    );

    // The most-negative value negates to itself, which is its correct unsigned magnitude
    assign mcand_mag  = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign mplier_mag = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign neg_d      = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);

    assign sum       = ca_q + (q_q[0] ? {1'b0, m_q} : '0);
    assign ca_d      = {1'b0, sum[WIDTH:1]};
    assign q_d       = {sum[0], q_q[WIDTH-1:1]};
    assign raw_prod  = {ca_d[WIDTH-1:0], q_d};
    assign product_d = neg_q ? -raw_prod : raw_prod;

    assign product = product_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ca_q      <= '0;
            q_q       <= '0;
            m_q       <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else if (load) begin
            ca_q  <= '0;
            q_q   <= mplier_mag;
            m_q   <= mcand_mag;
            neg_q <= neg_d;
        end else if (step) begin
            ca_q <= ca_d;
            q_q  <= q_d;
            if (finish) begin
                product_q <= product_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier (WIDTH 4 and 8)
module tb_seq_multiplier;

    localparam int W4 = 4;
    localparam int W8 = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st, sm;
    logic [3:0]  mc, mp;
    logic [7:0]  prod4;
    logic        rdy4, dn4;

    logic        st8, sm8;
    logic [7:0]  mc8, mp8;
    logic [15:0] prod8;
    logic        rdy8, dn8;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W4)) dut4 (
        .clock        (clk),
        .reset        (rst_n),
        .start        (st),
        .signed_mode  (sm),
        .multiplicand (mc),
        .multiplier   (mp),
        .product      (prod4),
        .ready        (rdy4),
        .done         (dn4)
    );

    seq_multiplier #(.WIDTH(W8)) dut8 (
        .clock        (clk),
        .reset        (rst_n),
        .start        (st8),
        .signed_mode  (sm8),
        .multiplicand (mc8),
        .multiplier   (mp8),
        .product      (prod8),
        .ready        (rdy8),
        .done         (dn8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref4(input logic s, input logic [3:0] a, input logic [3:0] b);
        longint x, y, p;
        x = s ? longint'($signed(a)) : longint'({1'b0, a});
        y = s ? longint'($signed(b)) : longint'({1'b0, b});
        p = x * y;
        return p[7:0];
    endfunction

    // Timeline model for the 4-bit instance: phase 0 idle, 1..W4 busy, W4+1 result cycle
    int         m_phase = 0;
    logic [7:0] m_exp   = '0;
    logic [7:0] m_prod  = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_prod  = '0;
        end else if (m_phase == 0) begin
            if (st) begin
                m_exp   = ref4(sm, mc, mp);
                m_phase = 1;
            end
        end else if (m_phase == W4 + 1) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == W4 + 1) m_prod = m_exp;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_ready",   64'(rdy4),  64'(m_phase == 0));
            check("mdl_done",    64'(dn4),   64'(m_phase == W4 + 1));
            check("mdl_product", 64'(prod4), 64'(m_prod));
        end
    end

    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b, input logic [7:0] lit);
        @(negedge clk);
        check("pre_ready", 64'(rdy4), 64'd1);
        st = 1'b1; sm = s; mc = a; mp = b;
        for (int i = 1; i <= W4 + 2; i++) begin
            @(negedge clk);
            st = 1'b0; mc = 4'hx; mp = 4'hx;
            if (i == 1) check("ready_drop", 64'(rdy4), 64'd0);
            if (i == W4) check("no_early_done", 64'(dn4), 64'd0);
            if (i == W4 + 1) begin
                check("done_pulse", 64'(dn4), 64'd1);
                check("lit_product", 64'(prod4), 64'(lit));
            end
            if (i == W4 + 2) begin
                check("ready_back", 64'(rdy4), 64'd1);
                check("done_low", 64'(dn4), 64'd0);
            end
        end
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] lit);
        @(negedge clk);
        st8 = 1'b1; sm8 = s; mc8 = a; mp8 = b;
        for (int i = 1; i <= W8 + 2; i++) begin
            @(negedge clk);
            st8 = 1'b0;
            if (i == W8) check("w8_no_early_done", 64'(dn8), 64'd0);
            if (i == W8 + 1) begin
                check("w8_done", 64'(dn8), 64'd1);
                check("w8_product", 64'(prod8), 64'(lit));
            end
            if (i == W8 + 2) check("w8_ready", 64'(rdy8), 64'd1);
        end
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        st = 1'b0; sm = 1'b0; mc = '0; mp = '0;
        st8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",   64'(rdy4),  64'd1);
        check("rst_done",    64'(dn4),   64'd0);
        check("rst_product", 64'(prod4), 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Model pins: hand-computed literals
        run4(1'b0, 4'd5,  4'd7,  8'h23);
        run4(1'b0, 4'd15, 4'd15, 8'hE1);
        run4(1'b0, 4'd8,  4'd15, 8'h78);
        run4(1'b1, 4'hD,  4'd5,  8'hF1);
        run4(1'b1, 4'h8,  4'h8,  8'h40);
        run4(1'b1, 4'h8,  4'd7,  8'hC8);
        run4(1'b1, 4'd0,  4'hF,  8'h00);
        run4(1'b1, 4'd3,  4'hE,  8'hFA);

        // Start held high with operands changing every cycle
        @(negedge clk);
        ndone = 0;
        st = 1'b1; sm = 1'b0; mc = 4'd9; mp = 4'd11;
        for (int i = 1; i <= 3 * (W4 + 2); i++) begin
            @(negedge clk);
            if (dn4) ndone++;
            sm = i[0]; mc = 4'(i * 3 + 1); mp = 4'(15 - i);
        end
        st = 1'b0;
        check("held_start_count", 64'(ndone), 64'd3);

        // Start pulsed mid-CALC must be ignored
        @(negedge clk);
        st = 1'b1; sm = 1'b0; mc = 4'd6; mp = 4'd5;
        @(negedge clk);
        st = 1'b0;
        @(negedge clk);
        st = 1'b1; mc = 4'd9; mp = 4'd9;
        @(negedge clk);
        st = 1'b0;
        repeat (2) @(negedge clk);
        check("ignored_start_done", 64'(dn4),   64'd1);
        check("ignored_start_prod", 64'(prod4), 64'h1E);
        @(negedge clk);

        // Reset asserted in the second CALC cycle
        @(negedge clk);
        st = 1'b1; sm = 1'b0; mc = 4'd7; mp = 4'd7;
        @(negedge clk);
        st = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ready",   64'(rdy4),  64'd1);
        check("midrst_done",    64'(dn4),   64'd0);
        check("midrst_product", 64'(prod4), 64'd0);
        rst_n = 1'b1;
        run4(1'b0, 4'd6, 4'd3, 8'h12);

        run8(1'b0, 8'd255, 8'd255, 16'hFE01);
        run8(1'b1, 8'h80,  8'h80,  16'h4000);
        run8(1'b1, 8'hFF,  8'd127, 16'hFF81);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier, the successor to the hardwired 4-bit lab multiplier. Operands are input ports, width is a parameter, and a runtime-selectable signed (two's complement) mode is added. A start/ready/done handshake replaces the free-running sequencer. The block sits between operand registers or switches and the result display/bus, and runs on the slow system clock.

## Interface
- `WIDTH`, default 4: operand width in bits, legal range 2–32; the product is 2·WIDTH bits.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `start`  in  1  request a multiply; accepted only when `ready`=1.
- `signed_mode`  in  1  0 = unsigned operands, 1 = two's-complement operands; sampled with `start`.
- `multiplicand`  in  WIDTH  M operand; sampled with `start`.
- `multiplier`  in  WIDTH  Q operand; sampled with `start`.
- `product`  out  2·WIDTH  registered result; holds the last result until the next completion.
- `ready`  out  1  block idle and able to accept `start`.
- `done`  out  1  one-cycle pulse; `product` is valid in the same cycle.

## Operation
- **States:** IDLE, CALC, DONE.
- **Reset (`reset`=0 at an edge):**
  - State → IDLE; `product`=0, `ready`=1, `done`=0.
  - Internal A, Q, C registers, counter and sign flag all cleared.
  - Reset overrides everything, including mid-CALC; no partial result is published.
- **IDLE:** `ready`=1. On `start`=1, load the operands and go to CALC.
  - A=0, C=0, count=WIDTH.
  - Q = |multiplier| and M = |multiplicand|. Magnitudes are taken only if `signed_mode`=1; otherwise the raw values are used.
  - neg = `signed_mode` & (multiplier[MSB] ^ multiplicand[MSB]).
  - Magnitude of the most-negative value (2^(WIDTH-1)) fits unsigned in WIDTH bits and needs no special case.
- **CALC, one iteration per cycle:**
  - {C,A} = A + (Q[0] ? M : 0), computed WIDTH+1 bits wide.
  - Then {C,A,Q} shifts right by one; C is refilled with 0.
  - count decrements. When count=1 at the edge, go to DONE and load `product` in the same edge.
  - `product` = neg ? −{A,Q} (mod 2^(2·WIDTH)) : {A,Q}, using post-final-iteration values.
- **DONE:** `done`=1 and `ready`=0 for exactly one cycle, then IDLE.
- `start` while in CALC or DONE is ignored and not queued.
- Operand inputs are don't-care except at the accepting edge.
- `signed_mode` affects only operand conditioning and the final negation; the datapath itself is always unsigned.

## Timing
- **Accept:** edge 0 with `ready`=1 and `start`=1.
- **Latency:** CALC occupies cycles 1..WIDTH. `done`=1 and the new `product` are visible in cycle WIDTH+1.
- `ready` returns to 1 in cycle WIDTH+2, so the earliest next accept is edge WIDTH+2 and back-to-back throughput is one result per WIDTH+2 cycles.
- `product` changes only at the DONE-entry edge or on reset; it is stable at all other times.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Structure
- **Package `mult_pkg`:**
  - `mult_state_t` enum (IDLE, CALC, DONE).
  - Function computing the counter width: $clog2(WIDTH+1).
- **Sub-module `mult_sequencer`:**
  - Contains the FSM and down-counter.
  - Inputs: `start`, counter-terminal.
  - Outputs: `load`, `step`, `finish`, `ready`, `done`.
- **Top level** holds the datapath registers (A, Q, M, C, neg, `product`) and the (WIDTH+1)-bit adder.

## Test plan
- WIDTH=4, unsigned, 5×7, start at edge 0 → `ready` drops in cycle 1; `done`=1 in cycle 5 with `product`=0x23; `ready`=1 in cycle 6.
- WIDTH=4, unsigned, 15×15 → 0xE1. WIDTH=8, unsigned, 255×255 → 0xFE01, `done` 9 cycles after accept.
- WIDTH=4, signed: −3×5 → 0xF1; −8×−8 → 0x40; −8×7 → 0xC8; 0×−1 → 0x00.
- `start` held high continuously with changing operands → only operands sampled on `ready` edges are used; results arrive every WIDTH+2 cycles.
- `start` pulsed during CALC with different operands → ignored; the original result is produced at the original `done` time.
- `reset`=0 in cycle 2 of CALC → next cycle `ready`=1, `done`=0, `product`=0; a subsequent 6×3 (unsigned) completes correctly to 0x12.
